// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, redirect, and decoder handshake.
// The master view belongs to the fetch stage; the slave view is its environment.
interface fetch_queue_if;
    logic [31:0] pc_addr_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        halted_o;

    modport master (
        output pc_addr_o,
        input  instr_i,
        input  redirect_i,
        input  redirect_addr_i,
        output instr_o,
        output pc_o,
        output valid_o,
        input  ready_i,
        output halted_o
    );

    modport slave (
        input  pc_addr_o,
        output instr_i,
        output redirect_i,
        output redirect_addr_i,
        input  instr_o,
        input  pc_o,
        input  valid_o,
        output ready_i,
        input  halted_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, captures words from a
// combinational instruction memory into a DEPTH-entry prefetch FIFO and
// presents {pc, instr} to the decoder over valid/ready.
// Optional macro FETCH_HALT_EN: fetching a zero word halts the stage until
// the next redirect; without it halted_o stays 0.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_queue_if.master bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    fetch_state_e     state_q, state_d;

    logic   empty_c;
    logic   full_c;
    logic   pop_c;
    logic   push_c;
    logic   halt_hit_c;
    entry_t head_c;

    // Handshake qualification: pop on valid&ready, push when there is room
    // (including a full queue that frees a slot this edge) and fetch is live.
    always_comb begin
        empty_c    = (cnt_q == '0);
        full_c     = (cnt_q == CNT_W'(DEPTH));
        pop_c      = !empty_c && bus.ready_i;
        push_c     = (!full_c || pop_c) && !bus.redirect_i && (state_q == FS_RUN);
        halt_hit_c = 1'b0;
`ifdef FETCH_HALT_EN
        halt_hit_c = push_c && (bus.instr_i == '0);
`endif
    end

    // Halt FSM next state: a pushed zero word halts; redirect always resumes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FS_RUN: begin
                if (!bus.redirect_i && halt_hit_c) begin
                    state_d = FS_HALT;
                end
            end
            FS_HALT: begin
                if (bus.redirect_i) begin
                    state_d = FS_RUN;
                end
            end
            default: state_d = FS_RUN;
        endcase
    end

    // Pointer, occupancy and fetch-PC next state; redirect outranks everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;

        if (bus.redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            pc_d     = bus.redirect_addr_i & 32'hFFFF_FFFC;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                // A halting word is kept but the PC stays on it.
                if (!halt_hit_c) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            pc_q     <= RESET_PC;
            state_q  <= FS_RUN;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            state_q  <= state_d;
        end
    end

    // Entry storage; stale contents are masked by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{pc: pc_q, instr: bus.instr_i};
        end
    end

    // Head entry and output drive; payload reads as zero while empty.
    always_comb begin
        head_c        = mem_q[rd_ptr_q];
        bus.pc_addr_o = pc_q;
        bus.valid_o   = !empty_c;
        bus.halted_o  = (state_q == FS_HALT);
        bus.pc_o      = empty_c ? '0 : head_c.pc;
        bus.instr_o   = empty_c ? '0 : head_c.instr;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_HALT_EN
    localparam bit          HALT_EN  = 1'b1;
    localparam logic [31:0] BIAS     = 32'h0000_0100;
`else
    localparam bit          HALT_EN  = 1'b0;
    localparam logic [31:0] BIAS     = 32'h0000_0000;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    bit   zero_c_en = 1'b0;

    fetch_queue_if bus();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: word k is k*0x11 (+bias); optionally zero at 0x0C.
    function automatic logic [31:0] word_of(input logic [31:0] a, input bit zc);
        if (zc && a == 32'h0000_000C) return 32'h0;
        return (a >> 2) * 32'h11 + BIAS;
    endfunction

    always_comb bus.instr_i = word_of(bus.pc_addr_o, zero_c_en);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input bit ev, input logic [31:0] epc,
                           input logic [31:0] ein, input logic [31:0] ea, input bit eh);
        chk({tag, ".valid"},  {31'b0, bus.valid_o},  {31'b0, ev});
        chk({tag, ".pc"},     bus.pc_o,              epc);
        chk({tag, ".instr"},  bus.instr_o,           ein);
        chk({tag, ".addr"},   bus.pc_addr_o,         ea);
        chk({tag, ".halted"}, {31'b0, bus.halted_o}, {31'b0, eh});
    endtask

    typedef struct {
        bit          rst;
        bit          ready;
        bit          redir;
        logic [31:0] raddr;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit rst, input bit rdy, input bit rd, input logic [31:0] ra,
                       input bit ev, input logic [31:0] epc, input logic [31:0] ea);
        vec_t v;
        v.rst    = rst;
        v.ready  = rdy;
        v.redir  = rd;
        v.raddr  = ra;
        v.ev     = ev;
        v.epc    = ev ? epc : 32'h0;
        v.einstr = ev ? word_of(epc, 1'b0) : 32'h0;
        v.eaddr  = ea;
        vt.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: queue of {pc, instr} pairs plus fetch PC and halt flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;

    task automatic model_step(input bit rdy, input bit rd, input logic [31:0] ra);
        bit          pop;
        bit          room;
        logic [31:0] w;
        ent_t        e;
        pop  = (mq.size() != 0) && rdy;
        room = (mq.size() < DEPTH) || pop;
        if (rd) begin
            mq.delete();
            m_pc   = {ra[31:2], 2'b00};
            m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (room && !m_halt) begin
                w       = word_of(m_pc, zero_c_en);
                e.pc    = m_pc;
                e.instr = w;
                mq.push_back(e);
                if (HALT_EN && w == 32'h0) m_halt = 1'b1;
                else                       m_pc   = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.ready_i         = 1'b0;
        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = 32'h0;

        // Streaming from reset.
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 32'h0, 32'h4);
        add(0, 1, 0, 0, 1, 32'h4, 32'h8);
        add(0, 1, 0, 0, 1, 32'h8, 32'hC);
        // Back-pressure for 8 cycles: queue fills, PC freezes at 0x10.
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0, 32'h4);
        add(0, 0, 0, 0, 1, 32'h0, 32'h8);
        add(0, 0, 0, 0, 1, 32'h0, 32'hC);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 32'h0, 32'h10);
        // Drain with refill while full.
        add(0, 1, 0, 0, 1, 32'h0,  32'h10);
        add(0, 1, 0, 0, 1, 32'h4,  32'h14);
        add(0, 1, 0, 0, 1, 32'h8,  32'h18);
        add(0, 1, 0, 0, 1, 32'hC,  32'h1C);
        add(0, 1, 0, 0, 1, 32'h10, 32'h20);
        // Redirect with 3 entries queued and a coincident pop; unaligned target.
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h0, 32'h4);
        add(0, 0, 0, 0, 1, 32'h0, 32'h8);
        add(0, 1, 1, 32'h43, 1, 32'h0, 32'hC);
        add(0, 1, 0, 0, 0, 0, 32'h40);
        add(0, 1, 0, 0, 1, 32'h40, 32'h44);
        // PC wrap at the top of the address space.
        add(0, 1, 1, 32'hFFFF_FFF8, 1, 32'h44, 32'h48);
        add(0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8);
        add(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        add(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
        add(0, 1, 0, 0, 1, 32'h0,         32'h4);

        foreach (vt[i]) begin
            rst_i               = vt[i].rst;
            bus.ready_i         = vt[i].ready;
            bus.redirect_i      = vt[i].redir;
            bus.redirect_addr_i = vt[i].raddr;
            #2;
            chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].einstr, vt[i].eaddr, 1'b0);
            next_cycle();
        end

        // Reset asserted between edges while streaming.
        bus.redirect_i = 1'b0;
        bus.ready_i    = 1'b1;
        rst_i          = 1'b1;
        #2;
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) next_cycle();
        chk("midrst.pre_valid", {31'b0, bus.valid_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk_all("midrst", 1'b0, 32'h0, 32'h0, RESET_PC, 1'b0);
        next_cycle();
        rst_i = 1'b0;

`ifdef FETCH_HALT_EN
        // Zero word at 0x0C: delivered, then fetch halts until a redirect.
        zero_c_en = 1'b1;
        rst_i     = 1'b1;
        #2;
        rst_i = 1'b0;
        chk_all("halt0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        next_cycle();
        chk_all("halt1", 1'b1, 32'h0, BIAS,                32'h4, 1'b0);
        next_cycle();
        chk_all("halt2", 1'b1, 32'h4, BIAS + 32'h11,       32'h8, 1'b0);
        next_cycle();
        chk_all("halt3", 1'b1, 32'h8, BIAS + 32'h22,       32'hC, 1'b0);
        next_cycle();
        chk_all("halt4", 1'b1, 32'hC, 32'h0,               32'hC, 1'b1);
        next_cycle();
        chk_all("halt5", 1'b0, 32'h0, 32'h0,               32'hC, 1'b1);
        next_cycle();
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = 32'h0;
        #2;
        chk_all("halt6", 1'b0, 32'h0, 32'h0,               32'hC, 1'b1);
        next_cycle();
        bus.redirect_i = 1'b0;
        #2;
        chk_all("halt7", 1'b0, 32'h0, 32'h0,               32'h0, 1'b0);
        next_cycle();
        chk_all("halt8", 1'b1, 32'h0, BIAS,                32'h4, 1'b0);
        next_cycle();
`endif

        // Randomized run against the reference model.
        zero_c_en           = 1'b1;
        bus.ready_i         = 1'b0;
        bus.redirect_i      = 1'b0;
        rst_i               = 1'b1;
        #2;
        rst_i = 1'b0;
        mq.delete();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bus.ready_i    = ($urandom_range(0, 9) < 7);
            bus.redirect_i = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0)
                bus.redirect_addr_i = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            else
                bus.redirect_addr_i = $urandom & 32'h3F;
            #2;
            chk_all($sformatf("rnd%0d", n), mq.size() != 0,
                    (mq.size() != 0) ? mq[0].pc    : 32'h0,
                    (mq.size() != 0) ? mq[0].instr : 32'h0,
                    m_pc, m_halt);
            model_step(bus.ready_i, bus.redirect_i, bus.redirect_addr_i);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the memory's byte address.
- Captures the returned word into a small prefetch FIFO and hands {pc, instr} pairs to the decoder over a valid/ready handshake.
- A redirect input (branch/jump) flushes the queue and reloads the PC.
- The instruction memory is a combinational read: the word for pc_addr_o is on instr_i in the same cycle.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- pc_addr_o  out  32  byte address to instruction memory (current fetch PC)
- instr_i  in  32  instruction word returned for pc_addr_o
- redirect_i  in  1  flush queue and load redirect_addr_i
- redirect_addr_i  in  32  new fetch PC (byte address)
- instr_o  out  32  instruction at FIFO head
- pc_o  out  32  PC of FIFO head entry
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  decoder accepts head this cycle
- halted_o  out  1  fetch halted (see Optional Feature)

Behaviour:
- Interface: one clock (clk_i). Reset rst_i is asynchronous and active-high.
- Reset values (async, immediate):
  - fetch PC = RESET_PC, so pc_addr_o = RESET_PC
  - FIFO empty: valid_o=0, count=0, rd_ptr=wr_ptr=0
  - instr_o=0, pc_o=0 while empty; halted_o=0
- Pop: occurs at the edge when valid_o && ready_i. ready_i while empty is ignored.
- Push: occurs at the edge when the queue has room and there is no redirect and no halt.
  - Room means count<DEPTH, or count==DEPTH with a pop in the same cycle.
  - Push writes {fetch PC, instr_i}, then fetch PC <= fetch PC + 4.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full with no pop: PC holds and pc_addr_o is stable; instr_i is re-sampled later.
- Redirect (highest priority):
  - At the edge: FIFO cleared (count=0, pointers=0) and fetch PC <= {redirect_addr_i[31:2], 2'b00}.
  - No push that cycle. A coincident pop is discarded; its head is still considered consumed by the decoder.
  - valid_o=0 in the cycle after a redirect.
- Latency: the first valid_o rises one cycle after reset deassertion or after a redirect. With ready_i held at 1 the throughput is 1 instr/cycle.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 0. Bits [1:0] are always 0.
- Outputs instr_o and pc_o are read combinationally from the head entry and are zero when empty.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation: all state returns to reset values at once. In-flight entries are lost.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - When a push would write instr_i==32'h0000_0000, the zero word is still pushed, and on that same edge halted_o<=1 and the PC holds (no +4).
  - While halted: no pushes; pops continue.
  - redirect_i clears halted_o at its edge and loads the PC as normal. Reset clears it.
- Undefined: halted_o tied to 0; zero words are fetched like any other.

Test Plan:
- Reset, RESET_PC=0, ready_i=1, memory words k*0x11: pc_addr_o steps 0,4,8,...; each cycle the decoder sees pc_o=4k, instr_o=k*0x11. valid_o is first high 1 cycle after reset drops.
- ready_i=0 for 8 cycles, DEPTH=4: count saturates at 4 after 4 edges; pc_addr_o freezes at 0x10. ready_i=1: entries pc 0,4,8,C emerge in order, then 0x10.
- Queue holding 3 entries, redirect_i=1 with redirect_addr_i=0x43 and ready_i=1 at the same edge: next cycle valid_o=0 and pc_addr_o=0x40. The following cycle pc_o=0x40.
- Full queue, ready_i=1 continuously: push and pop on the same edge, count stays 4, no entry lost or duplicated (scoreboard on pc_o sequence).
- Redirect to 0xFFFF_FFF8: pc sequence FFF8, FFFC, 0000.
- FETCH_HALT_EN: word at 0x0C is zero. Entries 0, 4, 8 and 0x0C (instr 0) are delivered, then halted_o=1 and pc_addr_o holds at 0x0C. Redirect to 0 clears the halt and fetching resumes.
- Reset mid-stream: assert rst_i between clock edges; valid_o drops immediately and pc_addr_o=RESET_PC.
